// File: rtl/ccx_arbiter_pkg.sv
// Shared CCX definitions: arbiter FSM encoding, port IDs and bus widths.
package ccx_arbiter_pkg;

  localparam int unsigned STRB_W = 8;

  localparam logic PORT_IMEM = 1'b0;
  localparam logic PORT_DMEM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } ccx_state_e;

endpackage

// File: rtl/ccx_rr_pick.sv
// Two-port round-robin pick: a lone requester wins, a tie goes to the port that did not own last.
module ccx_rr_pick
  import ccx_arbiter_pkg::*;
(
  input  logic imem_req,
  input  logic dmem_req,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = imem_req | dmem_req;
    winner = PORT_IMEM;
    if (imem_req && dmem_req) begin
      winner = (last_owner == PORT_IMEM) ? PORT_DMEM : PORT_IMEM;
    end else if (dmem_req) begin
      winner = PORT_DMEM;
    end
  end

endmodule

// File: rtl/ccx_arbiter.sv
// Merges the instruction and data memory ports onto one CCX bridge request with
// zero-latency arbitration in IDLE and a single outstanding transaction.
module ccx_arbiter
  import ccx_arbiter_pkg::*;
#(
  parameter int unsigned AW = 39,
  parameter int unsigned DW = 64
) (
  input  logic              g_clk,
  input  logic              g_reset,

  input  logic              imem_req,
  input  logic [AW-1:0]     imem_addr,
  output logic              imem_gnt,
  output logic              imem_err,
  output logic [DW-1:0]     imem_rdata,

  input  logic              dmem_req,
  input  logic              dmem_wen,
  input  logic [STRB_W-1:0] dmem_strb,
  input  logic [AW-1:0]     dmem_addr,
  input  logic [DW-1:0]     dmem_wdata,
  output logic              dmem_gnt,
  output logic              dmem_err,
  output logic [DW-1:0]     dmem_rdata,

  output logic              ccx_req,
  output logic              ccx_rtype,
  output logic [AW-1:0]     ccx_addr,
  output logic              ccx_wen,
  output logic [STRB_W-1:0] ccx_strb,
  output logic [DW-1:0]     ccx_wdata,
  input  logic              ccx_gnt,
  input  logic              ccx_err,
  input  logic [DW-1:0]     ccx_rdata
);

  ccx_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       pick_valid, pick_winner;
  logic       sel_dmem;

  ccx_rr_pick u_rr_pick (
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Reset leaves DMEM as last owner so IMEM takes the first tie.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= PORT_DMEM;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // ccx_gnt only steers grants and next state; ccx_req depends on state and requests alone.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    ccx_req      = 1'b0;
    sel_dmem     = 1'b0;
    imem_gnt     = 1'b0;
    dmem_gnt     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          ccx_req      = 1'b1;
          sel_dmem     = (pick_winner == PORT_DMEM);
          last_owner_d = pick_winner;
          state_d      = (pick_winner == PORT_DMEM) ? ST_BUSY_D : ST_BUSY_I;
        end
      end
      ST_BUSY_I: begin
        ccx_req = 1'b1;
        if (ccx_gnt) begin
          imem_gnt = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_BUSY_D: begin
        ccx_req  = 1'b1;
        sel_dmem = 1'b1;
        if (ccx_gnt) begin
          dmem_gnt = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction fetches are always reads with no write payload.
  assign ccx_rtype = sel_dmem;
  assign ccx_addr  = sel_dmem ? dmem_addr : imem_addr;
  assign ccx_wen   = sel_dmem & dmem_wen;
  assign ccx_strb  = sel_dmem ? dmem_strb : STRB_W'(0);
  assign ccx_wdata = sel_dmem ? dmem_wdata : DW'(0);

  assign imem_err   = ccx_err;
  assign imem_rdata = ccx_rdata;
  assign dmem_err   = ccx_err;
  assign dmem_rdata = ccx_rdata;

endmodule

// File: tb/tb_ccx_arbiter.sv
// Directed self-checking bench for ccx_arbiter.
module tb_ccx_arbiter;
  import ccx_arbiter_pkg::*;

  localparam int unsigned AW = 39;
  localparam int unsigned DW = 64;

  logic              g_clk;
  logic              g_reset;
  logic              imem_req;
  logic [AW-1:0]     imem_addr;
  logic              imem_gnt, imem_err;
  logic [DW-1:0]     imem_rdata;
  logic              dmem_req, dmem_wen;
  logic [STRB_W-1:0] dmem_strb;
  logic [AW-1:0]     dmem_addr;
  logic [DW-1:0]     dmem_wdata;
  logic              dmem_gnt, dmem_err;
  logic [DW-1:0]     dmem_rdata;
  logic              ccx_req, ccx_rtype, ccx_wen;
  logic [AW-1:0]     ccx_addr;
  logic [STRB_W-1:0] ccx_strb;
  logic [DW-1:0]     ccx_wdata;
  logic              ccx_gnt, ccx_err;
  logic [DW-1:0]     ccx_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  ccx_arbiter #(.AW(AW), .DW(DW)) dut (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_err   (imem_err),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_wen   (dmem_wen),
    .dmem_strb  (dmem_strb),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_err   (dmem_err),
    .dmem_rdata (dmem_rdata),
    .ccx_req    (ccx_req),
    .ccx_rtype  (ccx_rtype),
    .ccx_addr   (ccx_addr),
    .ccx_wen    (ccx_wen),
    .ccx_strb   (ccx_strb),
    .ccx_wdata  (ccx_wdata),
    .ccx_gnt    (ccx_gnt),
    .ccx_err    (ccx_err),
    .ccx_rdata  (ccx_rdata)
  );

  initial begin
    g_clk = 1'b0;
    forever #5 g_clk = ~g_clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    g_reset    = 1'b1;
    imem_req   = 1'b0;
    imem_addr  = '0;
    dmem_req   = 1'b0;
    dmem_wen   = 1'b0;
    dmem_strb  = '0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    ccx_gnt    = 1'b0;
    ccx_err    = 1'b0;
    ccx_rdata  = '0;

    // Reset state, including a bridge grant while reset is held
    #2;
    chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("rst_ccx_req", 64'(ccx_req), 64'd0);
    ccx_gnt = 1'b1;
    #1;
    chk("rst_imem_gnt", 64'(imem_gnt), 64'd0);
    chk("rst_dmem_gnt", 64'(dmem_gnt), 64'd0);
    ccx_gnt = 1'b0;
    tick();
    tick();
    g_reset = 1'b0;

    // Single imem fetch with zero-latency issue; dmem inputs hold junk that must not leak
    imem_req   = 1'b1;
    imem_addr  = AW'(39'h100);
    dmem_addr  = AW'(39'h7777);
    dmem_wen   = 1'b1;
    dmem_strb  = 8'hFF;
    dmem_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("i_issue_req", 64'(ccx_req), 64'd1);
    chk("i_issue_addr", 64'(ccx_addr), 64'h100);
    chk("i_issue_rtype", 64'(ccx_rtype), 64'd0);
    chk("i_issue_wen", 64'(ccx_wen), 64'd0);
    chk("i_issue_strb", 64'(ccx_strb), 64'd0);
    chk("i_issue_wdata", 64'(ccx_wdata), 64'd0);
    tick();
    chk("i_busy_state", 64'(dut.state_q), 64'(ST_BUSY_I));
    chk("i_busy_no_gnt", 64'(imem_gnt), 64'd0);
    tick();
    tick();
    ccx_gnt = 1'b1;
    #1;
    chk("i_gnt", 64'(imem_gnt), 64'd1);
    chk("i_gnt_no_dmem", 64'(dmem_gnt), 64'd0);
    tick();
    imem_req = 1'b0;
    ccx_gnt  = 1'b0;
    #1;
    chk("i_done_idle", 64'(dut.state_q), 64'(ST_IDLE));
    chk("i_done_req", 64'(ccx_req), 64'd0);

    // Tie right after reset: imem first, then the dmem write
    g_reset = 1'b1;
    #1;
    g_reset = 1'b0;
    imem_req   = 1'b1;
    imem_addr  = AW'(39'h200);
    dmem_req   = 1'b1;
    dmem_addr  = AW'(39'h2000);
    dmem_wen   = 1'b1;
    dmem_strb  = 8'h0F;
    dmem_wdata = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("tie_addr", 64'(ccx_addr), 64'h200);
    chk("tie_rtype", 64'(ccx_rtype), 64'd0);
    tick();
    ccx_gnt = 1'b1;
    #1;
    chk("tie_i_gnt", 64'(imem_gnt), 64'd1);
    chk("tie_i_no_dgnt", 64'(dmem_gnt), 64'd0);
    tick();
    imem_req = 1'b0;
    ccx_gnt  = 1'b0;
    #1;
    chk("tie_d_req", 64'(ccx_req), 64'd1);
    chk("tie_d_rtype", 64'(ccx_rtype), 64'd1);
    chk("tie_d_addr", 64'(ccx_addr), 64'h2000);
    chk("tie_d_wen", 64'(ccx_wen), 64'd1);
    chk("tie_d_strb", 64'(ccx_strb), 64'h0F);
    chk("tie_d_wdata", 64'(ccx_wdata), 64'h0123_4567_89AB_CDEF);
    tick();
    ccx_gnt = 1'b1;
    #1;
    chk("tie_d_gnt", 64'(dmem_gnt), 64'd1);
    chk("tie_d_no_igng", 64'(imem_gnt), 64'd0);
    tick();
    dmem_req  = 1'b0;
    ccx_gnt   = 1'b0;
    ccx_err   = 1'b1;
    ccx_rdata = 64'h0000_0000_DEAD_BEEF;
    #1;
    chk("resp_d_err", 64'(dmem_err), 64'd1);
    chk("resp_d_rdata", 64'(dmem_rdata), 64'h0000_0000_DEAD_BEEF);
    chk("resp_i_rdata", 64'(imem_rdata), 64'h0000_0000_DEAD_BEEF);
    chk("resp_no_dgnt", 64'(dmem_gnt), 64'd0);
    ccx_err   = 1'b0;
    ccx_rdata = '0;

    // Both held continuously: grants alternate I,D,I,D,I,D
    imem_req  = 1'b1;
    dmem_req  = 1'b1;
    imem_addr = AW'(39'h300);
    dmem_addr = AW'(39'h3300);
    for (int t = 0; t < 6; t++) begin
      logic exp_d;
      exp_d = 1'(t % 2);
      #1;
      chk($sformatf("rr_rtype_%0d", t), 64'(ccx_rtype), 64'(exp_d));
      tick();
      ccx_gnt = 1'b1;
      #1;
      chk($sformatf("rr_igng_%0d", t), 64'(imem_gnt), 64'(!exp_d));
      chk($sformatf("rr_dgnt_%0d", t), 64'(dmem_gnt), 64'(exp_d));
      tick();
      ccx_gnt = 1'b0;
    end
    imem_req = 1'b0;
    dmem_req = 1'b0;
    #1;
    chk("rr_end_req", 64'(ccx_req), 64'd0);

    // dmem owns; imem request arriving mid-transaction waits
    dmem_req  = 1'b1;
    dmem_addr = AW'(39'h3000);
    dmem_wen  = 1'b0;
    #1;
    chk("own_d_rtype", 64'(ccx_rtype), 64'd1);
    tick();
    imem_req  = 1'b1;
    imem_addr = AW'(39'h400);
    #1;
    chk("own_d_addr", 64'(ccx_addr), 64'h3000);
    chk("own_d_rtype_busy", 64'(ccx_rtype), 64'd1);
    chk("own_d_no_igng", 64'(imem_gnt), 64'd0);
    tick();
    chk("own_d_addr2", 64'(ccx_addr), 64'h3000);
    ccx_gnt = 1'b1;
    #1;
    chk("own_d_gnt", 64'(dmem_gnt), 64'd1);
    chk("own_d_gnt_no_i", 64'(imem_gnt), 64'd0);
    tick();
    dmem_req = 1'b0;
    ccx_gnt  = 1'b0;
    #1;
    chk("own_i_addr", 64'(ccx_addr), 64'h400);
    chk("own_i_rtype", 64'(ccx_rtype), 64'd0);

    // Owner drops req before gnt: FSM stays busy and keeps ccx_req high
    tick();
    imem_req = 1'b0;
    #1;
    chk("drop_req", 64'(ccx_req), 64'd1);
    chk("drop_state", 64'(dut.state_q), 64'(ST_BUSY_I));
    tick();
    chk("drop_state2", 64'(dut.state_q), 64'(ST_BUSY_I));
    ccx_gnt = 1'b1;
    #1;
    chk("drop_gnt", 64'(imem_gnt), 64'd1);
    tick();
    ccx_gnt = 1'b0;
    #1;
    chk("drop_idle", 64'(dut.state_q), 64'(ST_IDLE));

    // Reset pulse during BUSY_D abandons dmem; tie afterwards goes to imem
    dmem_req  = 1'b1;
    dmem_addr = AW'(39'h5000);
    tick();
    chk("rd_busy_d", 64'(dut.state_q), 64'(ST_BUSY_D));
    ccx_gnt = 1'b1;
    g_reset = 1'b1;
    #1;
    chk("rd_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("rd_no_dgnt", 64'(dmem_gnt), 64'd0);
    chk("rd_no_igng", 64'(imem_gnt), 64'd0);
    chk("rd_req", 64'(ccx_req), 64'd1);
    imem_req  = 1'b1;
    imem_addr = AW'(39'h600);
    #1;
    chk("rd_tie_rtype", 64'(ccx_rtype), 64'd0);
    chk("rd_tie_addr", 64'(ccx_addr), 64'h600);
    ccx_gnt = 1'b0;
    tick();
    chk("rd_held_idle", 64'(dut.state_q), 64'(ST_IDLE));
    g_reset = 1'b0;
    tick();
    chk("rd_busy_i", 64'(dut.state_q), 64'(ST_BUSY_I));
    ccx_gnt = 1'b1;
    #1;
    chk("rd_i_gnt", 64'(imem_gnt), 64'd1);
    tick();
    imem_req = 1'b0;
    ccx_gnt  = 1'b0;
    #1;
    chk("rd_d_addr", 64'(ccx_addr), 64'h5000);
    chk("rd_d_rtype", 64'(ccx_rtype), 64'd1);
    tick();
    ccx_gnt = 1'b1;
    #1;
    chk("rd_d_gnt", 64'(dmem_gnt), 64'd1);
    tick();
    dmem_req = 1'b0;
    ccx_gnt  = 1'b0;

    // Spurious bridge grant while idle is ignored
    #1;
    ccx_gnt = 1'b1;
    #1;
    chk("sp_no_igng", 64'(imem_gnt), 64'd0);
    chk("sp_no_dgnt", 64'(dmem_gnt), 64'd0);
    chk("sp_req", 64'(ccx_req), 64'd0);
    tick();
    chk("sp_state", 64'(dut.state_q), 64'(ST_IDLE));
    ccx_gnt = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ccx_arbiter.md
CCX_ARBITER -- requirements
Module: ccx_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 39, address width; DW, default 64, data width.
REQ-002 g_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 g_reset  in  1  reset; asynchronous, active-high.
REQ-004 imem_req / imem_addr  in  1 / AW  instruction-port request, held until imem_gnt; read-only.
REQ-005 imem_gnt / imem_err / imem_rdata  out  1 / 1 / DW  instruction-port response.
REQ-006 dmem_req / dmem_wen / dmem_strb / dmem_addr / dmem_wdata  in  1 / 1 / 8 / AW / DW  data-port request, held stable until dmem_gnt.
REQ-007 dmem_gnt / dmem_err / dmem_rdata  out  1 / 1 / DW  data-port response.
REQ-008 ccx_req / ccx_rtype / ccx_addr / ccx_wen / ccx_strb / ccx_wdata  out  1 / 1 / AW / 1 / 8 / DW  merged request to the CCX-to-AXI4-Lite bridge.
REQ-009 ccx_gnt / ccx_err / ccx_rdata  in  1 / 1 / DW  bridge response; gnt marks completion; err/rdata valid from the cycle after gnt.

Function
REQ-010 FSM states SHALL be IDLE, BUSY_I and BUSY_D.
REQ-011 IDLE: winner chosen combinationally; ccx_* SHALL carry the winner's request in that same cycle (zero added latency).
REQ-012 IDLE with one requester: that port wins; with both: the port other than last_owner wins (round-robin).
REQ-013 IDLE with a winner -> BUSY_I (imem wins) or BUSY_D (dmem wins) next cycle; last_owner updated to the winner.
REQ-014 BUSY_x: ccx_* SHALL mux only the owner's live inputs; the other port's req is ignored and gets no gnt.
REQ-015 BUSY_x with ccx_gnt=1: owner gnt=1 that cycle; next state IDLE; a new arbitration starts no earlier than the following cycle.
REQ-016 ccx_gnt while IDLE (spurious) SHALL be ignored: no upstream gnt, no state change.
REQ-017 imem path: ccx_rtype=0, ccx_wen=0, ccx_strb=8'h00, ccx_wdata=0; dmem path: ccx_rtype=1, remaining fields pass through.
REQ-018 ccx_req=0 whenever IDLE with no requester; ccx_req=1 throughout BUSY_x regardless of the owner's req.
REQ-019 Owner deasserting req before gnt is a protocol violation; the FSM SHALL remain in BUSY_x until ccx_gnt.
REQ-020 imem_gnt = ccx_gnt & (state==BUSY_I); dmem_gnt = ccx_gnt & (state==BUSY_D); never both high.
REQ-021 imem_rdata, dmem_rdata = ccx_rdata and imem_err, dmem_err = ccx_err, broadcast unregistered; only the granted port consumes them.
REQ-022 At most one transaction SHALL be outstanding downstream at any time.

Reset
REQ-023 Asserting g_reset SHALL immediately force state=IDLE and last_owner=DMEM, so imem wins the first tie.
REQ-024 During reset all gnt outputs SHALL be 0; ccx_req follows REQ-011/REQ-012 from IDLE.
REQ-025 Reset mid-transaction SHALL abandon the owner; the system resets the bridge together with the arbiter.

Structure
REQ-026 FSM state encodings and port-ID constants (IMEM=0, DMEM=1) SHALL live in the shared CCX definitions file.
REQ-027 The round-robin decision SHALL be a sub-module ccx_rr_pick (inputs: two reqs, last_owner; outputs: valid, winner).
REQ-028 Implementation SHALL be 120-400 lines, with no RAMs and no combinational path from ccx_gnt to ccx_req.

Verification
REQ-029 Reset release; imem_req=1, addr=0x100 -> same cycle ccx_req=1, ccx_addr=0x100, rtype=0; gnt 3 cycles later -> imem_gnt=1 one cycle, FSM IDLE next.
REQ-030 Both requests together after reset -> imem served first; after its gnt, dmem (addr=0x2000, wen=1, strb=8'h0F) issued next cycle with ccx_strb=8'h0F.
REQ-031 Both held continuously over 6 transactions -> grants alternate I,D,I,D,I,D; no gnt overlaps.
REQ-032 dmem owner, imem_req rises mid-transaction -> ccx_addr unchanged, imem_gnt=0 until dmem completes.
REQ-033 g_reset pulsed during BUSY_D -> state IDLE immediately, dmem_gnt=0; later imem/dmem tie -> imem wins.
REQ-034 Spurious ccx_gnt in IDLE -> no imem_gnt/dmem_gnt; ccx_err=1 with rdata=0xDEADBEEF after a dmem gnt -> dmem_err=1, dmem_rdata=0xDEADBEEF next cycle.
